// File: rtl/axi_wr_sched_pkg.sv
// axi_wr_sched_pkg: shared types, requester ids and FIFO pointer-width helper for axi_wr_sched
package axi_wr_sched_pkg;
  typedef enum logic {AW_IDLE, AW_HOLD} aw_state_e;
  localparam int REQ_ICACHE = 0;
  localparam int REQ_BYPASS = 1;
  localparam int REQ_DCACHE = 2;
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/wr_order_fifo.sv
// wr_order_fifo: non-fall-through FIFO; ports: clk_i/rst_i, push/din, pop/dout, full/empty
module wr_order_fifo
  import axi_wr_sched_pkg::*;
#(
  parameter int Depth = 4,
  parameter int Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [Width-1:0] din,
  input  logic             pop,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = ptr_w(Depth);
  logic [Width-1:0] mem [Depth];
  logic [PW-1:0] wp, rp;
  logic [PW:0] cnt;
  logic push_ok, pop_ok;
  assign full = cnt == (PW+1)'(Depth);
  assign empty = cnt == '0;
  assign push_ok = push & ~full;
  assign pop_ok = pop & ~empty;
  assign dout = mem[rp];
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wp] <= din;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wp + PW'(push_ok);
      rp <= rp + PW'(pop_ok);
      cnt <= cnt + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    end
  end
endmodule

// File: rtl/axi_wr_sched.sv
// axi_wr_sched: AXI write scheduler; round-robin AW arbitration over NumReq requesters,
// W steering in AW grant order, cap on writes awaiting B. Ports: req_aw_*/req_w_* per
// requester, aw_*/w_* master side, b_done_i B completion, stall_cnt_o cap-stall counter
// (live only when AXI_WR_SCHED_STATS_EN is defined, otherwise tied to 0).
module axi_wr_sched
  import axi_wr_sched_pkg::*;
#(
  parameter int NumReq = 3,
  parameter int AwWidth = 64,
  parameter int WWidth = 73,
  parameter int MaxOutstanding = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NumReq-1:0]         req_aw_valid_i,
  output logic [NumReq-1:0]         req_aw_ready_o,
  input  logic [NumReq*AwWidth-1:0] req_aw_i,
  input  logic [NumReq-1:0]         req_w_valid_i,
  output logic [NumReq-1:0]         req_w_ready_o,
  input  logic [NumReq*WWidth-1:0]  req_w_i,
  input  logic [NumReq-1:0]         req_w_last_i,
  output logic                      aw_valid_o,
  input  logic                      aw_ready_i,
  output logic [AwWidth-1:0]        aw_o,
  output logic                      w_valid_o,
  input  logic                      w_ready_i,
  output logic [WWidth-1:0]         w_o,
  output logic                      w_last_o,
  input  logic                      b_done_i,
  output logic [15:0]               stall_cnt_o
);
  localparam int IW = $clog2(NumReq);
  localparam int OW = $clog2(MaxOutstanding) + 1;
  aw_state_e state, nstate;
  logic [IW-1:0] rr, hold_idx, pick, gidx, s;
  logic [OW-1:0] outst;
  logic found, aw_v, hs, pop, full, empty, cap_ok, dec;
  logic [2*NumReq-1:0] dbl;
  logic [NumReq-1:0] rot;
  logic [IW:0] off, sum;
  logic [AwWidth-1:0] aw_arr [NumReq];
  logic [WWidth-1:0] w_arr [NumReq];
  for (genvar g = 0; g < NumReq; g++) begin : g_slice
    assign aw_arr[g] = req_aw_i[g*AwWidth +: AwWidth];
    assign w_arr[g] = req_w_i[g*WWidth +: WWidth];
  end
  // Grant budget uses only registered state, so same-cycle pops/B completions free nothing yet.
  assign cap_ok = (outst != OW'(MaxOutstanding)) && !full;
  // Rotate valids so the rr pointer lands at bit 0; lowest set bit is the next in turn.
  always_comb begin
    dbl = {req_aw_valid_i, req_aw_valid_i} >> rr;
    rot = dbl[NumReq-1:0];
    found = 1'b0;
    off = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off = (IW+1)'(i);
      end
    end
    sum = off + {1'b0, rr};
    pick = (sum >= (IW+1)'(NumReq)) ? IW'(sum - (IW+1)'(NumReq)) : IW'(sum);
  end
  always_comb begin
    aw_v = 1'b0;
    gidx = pick;
    nstate = state;
    if (state == AW_HOLD) begin
      aw_v = 1'b1;
      gidx = hold_idx;
      nstate = aw_ready_i ? AW_IDLE : AW_HOLD;
    end else if (found && cap_ok) begin
      aw_v = 1'b1;
      nstate = aw_ready_i ? AW_IDLE : AW_HOLD;
    end
  end
  assign aw_valid_o = aw_v & ~rst_i;
  assign hs = aw_valid_o & aw_ready_i;
  assign aw_o = aw_arr[gidx];
  assign req_aw_ready_o = hs ? (NumReq'(1) << gidx) : '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= AW_IDLE;
      rr <= '0;
      hold_idx <= '0;
    end else begin
      state <= nstate;
      if (state == AW_IDLE) hold_idx <= pick;
      if (hs) rr <= (gidx == IW'(NumReq - 1)) ? '0 : gidx + 1'b1;
    end
  end
  wr_order_fifo #(.Depth(MaxOutstanding), .Width(IW)) u_fifo (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push(hs),
    .din(gidx),
    .pop(pop),
    .dout(s),
    .full(full),
    .empty(empty)
  );
  assign w_valid_o = ~empty & ~rst_i & req_w_valid_i[s];
  assign w_last_o = ~empty & ~rst_i & req_w_last_i[s];
  assign w_o = w_arr[s];
  assign req_w_ready_o = (~empty & ~rst_i) ? (NumReq'(w_ready_i) << s) : '0;
  assign pop = w_valid_o & w_ready_i & w_last_o;
  assign dec = b_done_i && (outst != '0);
  always_ff @(posedge clk_i) begin
    if (rst_i) outst <= '0;
    else outst <= outst + OW'(hs) - OW'(dec);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) assert (!(b_done_i && outst == '0));
  end
`ifdef AXI_WR_SCHED_STATS_EN
  logic [15:0] stall_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt <= '0;
    else if (state == AW_IDLE && |req_aw_valid_i && !cap_ok && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_axi_wr_sched.sv
// tb_axi_wr_sched: directed table and corner-case sequences for axi_wr_sched
module tb_axi_wr_sched;
  localparam int N = 3;
  localparam int AW = 64;
  localparam int WW = 73;
  logic clk = 1'b0;
  logic rst_i;
  logic [N-1:0] req_aw_valid_i, req_aw_ready_o, req_w_valid_i, req_w_ready_o, req_w_last_i;
  logic [N*AW-1:0] req_aw_i;
  logic [N*WW-1:0] req_w_i;
  logic aw_valid_o, aw_ready_i, w_valid_o, w_ready_i, w_last_o, b_done_i;
  logic [AW-1:0] aw_o;
  logic [WW-1:0] w_o;
  logic [15:0] stall_cnt_o;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  axi_wr_sched #(.NumReq(N), .AwWidth(AW), .WWidth(WW), .MaxOutstanding(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_aw_valid_i(req_aw_valid_i), .req_aw_ready_o(req_aw_ready_o), .req_aw_i(req_aw_i),
    .req_w_valid_i(req_w_valid_i), .req_w_ready_o(req_w_ready_o), .req_w_i(req_w_i),
    .req_w_last_i(req_w_last_i),
    .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_o(aw_o),
    .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_o(w_o), .w_last_o(w_last_o),
    .b_done_i(b_done_i), .stall_cnt_o(stall_cnt_o)
  );
  typedef struct {
    logic [2:0] awv; logic awr; logic [2:0] wv; logic [2:0] wl; logic wr; logic bd;
    logic eav; logic [2:0] eawr; int eidx; logic ewv; logic [2:0] ewr; logic ewl; int ewidx;
  } vec_t;
  vec_t tv [13];
  function automatic logic [AW-1:0] aw_sl(input int k);
    return 64'hA0A0_0000_0000_0000 + 64'(k);
  endfunction
  function automatic logic [WW-1:0] w_sl(input int k);
    return {9'h1AB, 64'hB0B0_0000_0000_0000 + 64'(k)};
  endfunction
  function automatic logic [8:0] status();
    return {aw_valid_o, req_aw_ready_o, w_valid_o, req_w_ready_o, w_last_o};
  endfunction
  task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic set(input logic [2:0] awv, input logic awr, input logic [2:0] wv,
                     input logic [2:0] wl, input logic wr, input logic bd);
    req_aw_valid_i = awv; aw_ready_i = awr; req_w_valid_i = wv;
    req_w_last_i = wl; w_ready_i = wr; b_done_i = bd;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic st(input string name, input logic [8:0] exp);
    @(negedge clk);
    chk(name, WW'(status()), WW'(exp));
  endtask
  task automatic do_reset();
    rst_i = 1'b1;
    set(3'b111, 1'b1, 3'b111, 3'b111, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", WW'(status()), '0);
    chk("reset_stall", WW'(stall_cnt_o), '0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    set('0, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask
  initial begin
    for (int k = 0; k < N; k++) begin
      req_aw_i[k*AW +: AW] = aw_sl(k);
      req_w_i[k*WW +: WW] = w_sl(k);
    end
    tv[0]  = '{3'b111, 1, 3'b111, 3'b000, 1, 0,  1, 3'b001, 0,  0, 3'b000, 0, 0};
    tv[1]  = '{3'b110, 1, 3'b111, 3'b000, 1, 0,  1, 3'b010, 1,  1, 3'b001, 0, 0};
    tv[2]  = '{3'b100, 1, 3'b111, 3'b001, 1, 0,  1, 3'b100, 2,  1, 3'b001, 1, 0};
    tv[3]  = '{3'b111, 1, 3'b111, 3'b000, 1, 0,  1, 3'b001, 0,  1, 3'b010, 0, 1};
    tv[4]  = '{3'b110, 1, 3'b111, 3'b010, 1, 1,  0, 3'b000, 0,  1, 3'b010, 1, 1};
    tv[5]  = '{3'b110, 1, 3'b111, 3'b000, 1, 0,  1, 3'b010, 1,  1, 3'b100, 0, 2};
    tv[6]  = '{3'b100, 1, 3'b111, 3'b100, 1, 0,  0, 3'b000, 0,  1, 3'b100, 1, 2};
    tv[7]  = '{3'b100, 1, 3'b111, 3'b000, 1, 1,  0, 3'b000, 0,  1, 3'b001, 0, 0};
    tv[8]  = '{3'b100, 1, 3'b111, 3'b001, 1, 1,  1, 3'b100, 2,  1, 3'b001, 1, 0};
    tv[9]  = '{3'b000, 1, 3'b111, 3'b010, 0, 1,  0, 3'b000, 0,  1, 3'b000, 1, 1};
    tv[10] = '{3'b000, 1, 3'b111, 3'b010, 1, 0,  0, 3'b000, 0,  1, 3'b010, 1, 1};
    tv[11] = '{3'b000, 1, 3'b111, 3'b100, 1, 1,  0, 3'b000, 0,  1, 3'b100, 1, 2};
    tv[12] = '{3'b000, 1, 3'b111, 3'b000, 1, 1,  0, 3'b000, 0,  0, 3'b000, 0, 0};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      set(tv[i].awv, tv[i].awr, tv[i].wv, tv[i].wl, tv[i].wr, tv[i].bd);
      st($sformatf("rr_row%0d", i), {tv[i].eav, tv[i].eawr, tv[i].ewv, tv[i].ewr, tv[i].ewl});
      if (tv[i].eav) chk($sformatf("rr_aw_row%0d", i), WW'(aw_o), WW'(aw_sl(tv[i].eidx)));
      if (tv[i].ewv) chk($sformatf("rr_w_row%0d", i), w_o, w_sl(tv[i].ewidx));
      tick();
    end
`ifdef AXI_WR_SCHED_STATS_EN
    chk("rr_stall_cnt", WW'(stall_cnt_o), WW'(3));
`else
    chk("rr_stall_cnt", WW'(stall_cnt_o), '0);
`endif
    do_reset();
    set(3'b100, 0, 3'b000, 3'b000, 0, 0);
    st("hold_c0", 9'b1_000_0_000_0); chk("hold_aw_c0", WW'(aw_o), WW'(aw_sl(2))); tick();
    for (int i = 1; i < 3; i++) begin
      set(3'b101, 0, 3'b000, 3'b000, 0, 0);
      st($sformatf("hold_c%0d", i), 9'b1_000_0_000_0);
      chk($sformatf("hold_aw_c%0d", i), WW'(aw_o), WW'(aw_sl(2)));
      tick();
    end
    set(3'b101, 1, 3'b000, 3'b000, 0, 0);
    st("hold_hs", 9'b1_100_0_000_0); chk("hold_aw_hs", WW'(aw_o), WW'(aw_sl(2))); tick();
    set(3'b001, 1, 3'b000, 3'b000, 0, 0);
    st("hold_next", 9'b1_001_0_000_0); chk("hold_aw_next", WW'(aw_o), WW'(aw_sl(0))); tick();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set(3'b001, 1, 3'b001, 3'b001, 1, 0);
      st($sformatf("cap_hs%0d", i), (i == 0) ? 9'b1_001_0_000_0 : 9'b1_001_1_001_1);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      set(3'b001, 1, 3'b001, 3'b001, 1, 0);
      st($sformatf("cap_stall%0d", i), (i == 0) ? 9'b0_000_1_001_1 : 9'b0_000_0_000_0);
      tick();
    end
    set(3'b001, 1, 3'b001, 3'b001, 1, 1);
    st("cap_bdone", 9'b0_000_0_000_0); tick();
    set(3'b001, 1, 3'b000, 3'b000, 1, 0);
    st("cap_regrant", 9'b1_001_0_000_0); tick();
`ifdef AXI_WR_SCHED_STATS_EN
    chk("cap_stall_cnt", WW'(stall_cnt_o), WW'(4));
`else
    chk("cap_stall_cnt", WW'(stall_cnt_o), '0);
`endif
    do_reset();
    set(3'b010, 0, 3'b010, 3'b000, 1, 0);
    st("early_w_c0", 9'b1_000_0_000_0); tick();
    set(3'b010, 1, 3'b010, 3'b000, 1, 0);
    st("early_w_hs", 9'b1_010_0_000_0); tick();
    set(3'b000, 0, 3'b010, 3'b000, 1, 0);
    st("early_w_b0", 9'b0_000_1_010_0); chk("early_w_data", w_o, w_sl(1)); tick();
    set(3'b000, 0, 3'b010, 3'b010, 1, 0);
    st("early_w_b1", 9'b0_000_1_010_1); tick();
    st("early_w_done", 9'b0_000_0_000_0); tick();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set(3'b001, 1, 3'b000, 3'b000, 0, 0);
      st($sformatf("full_hs%0d", i), 9'b1_001_0_000_0);
      tick();
    end
    set(3'b001, 1, 3'b000, 3'b000, 0, 1);
    st("full_bdone", 9'b0_000_0_000_0); tick();
    set(3'b001, 1, 3'b001, 3'b001, 1, 0);
    st("full_pop_block", 9'b0_000_1_001_1); tick();
    set(3'b001, 1, 3'b000, 3'b000, 1, 0);
    st("full_grant", 9'b1_001_0_001_0); tick();
    for (int i = 0; i < 4; i++) begin
      set(3'b000, 0, 3'b001, 3'b001, 1, 0);
      st($sformatf("full_drain%0d", i), 9'b0_000_1_001_1);
      tick();
    end
    st("full_empty", 9'b0_000_0_000_0); tick();
    do_reset();
    set(3'b100, 1, 3'b000, 3'b000, 1, 0);
    st("mid_hs", 9'b1_100_0_000_0); tick();
    set(3'b000, 0, 3'b100, 3'b000, 1, 0);
    st("mid_beat", 9'b0_000_1_100_0); chk("mid_beat_data", w_o, w_sl(2)); tick();
    rst_i = 1'b1;
    st("mid_in_reset", 9'b0_000_0_000_0); tick();
    rst_i = 1'b0;
    set(3'b000, 0, 3'b100, 3'b100, 1, 0);
    st("mid_after", 9'b0_000_0_000_0); chk("mid_after_stall", WW'(stall_cnt_o), '0); tick();
    set(3'b001, 1, 3'b100, 3'b100, 1, 0);
    st("mid_fresh_hs", 9'b1_001_0_000_0); chk("mid_fresh_aw", WW'(aw_o), WW'(aw_sl(0))); tick();
    set(3'b000, 0, 3'b101, 3'b101, 1, 0);
    st("mid_fresh_w", 9'b0_000_1_001_1); chk("mid_fresh_wdata", w_o, w_sl(0)); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
